// File: rtl/lift_shaft_model.sv
// Plant model of the lift cab and shaft: integrates engine commands into a cab position and
// derives the floor-zone and exact-stop detectors, flagging illegal engine commands.
module lift_shaft_model #(
  parameter int unsigned FLOOR_NUM       = 16,
  parameter int unsigned STEPS_PER_FLOOR = 8,
  parameter int unsigned STEP_CYCLES     = 4,
  parameter int unsigned INIT_FLOOR      = 0,
  localparam int unsigned MAX_POS        = (FLOOR_NUM - 1) * STEPS_PER_FLOOR,
  localparam int unsigned POS_W          = $clog2(MAX_POS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  // [1] = up, [0] = down (bit-compatible with the packed {up, down} direction struct)
  input  logic [1:0]           lift_engine,
  output logic [FLOOR_NUM-1:0] lift_detector,
  output logic [FLOOR_NUM-1:0] lift_stop_detector,
  output logic [POS_W-1:0]     position,
  output logic                 moving,
  output logic                 fault,
  output logic [1:0]           fault_code
);

  localparam int unsigned CNT_W = $clog2(STEP_CYCLES) + 1;
  localparam int unsigned HALF  = STEPS_PER_FLOOR / 2;

  localparam logic [1:0] DIR_NONE = 2'd0;
  localparam logic [1:0] DIR_UP   = 2'd1;
  localparam logic [1:0] DIR_DOWN = 2'd2;
  localparam logic [1:0] DIR_BOTH = 2'd3;

  localparam logic [1:0] FC_NONE = 2'd0;
  localparam logic [1:0] FC_BOTH = 2'd1;
  localparam logic [1:0] FC_OVER = 2'd2;
  localparam logic [1:0] FC_REV  = 2'd3;

  localparam logic [POS_W-1:0] INIT_POS = POS_W'(INIT_FLOOR * STEPS_PER_FLOOR);
  localparam logic [POS_W-1:0] TOP_POS  = POS_W'(MAX_POS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEP_CYCLES - 1);

  logic [POS_W-1:0] r_position;
  logic [CNT_W-1:0] r_step_cnt;
  logic [1:0]       r_prev_dir;
  logic             r_moving;
  logic             r_fault;
  logic [1:0]       r_fault_code;

  logic [1:0]       w_dir;
  logic             w_active;
  logic [CNT_W-1:0] w_eff_cnt;
  logic             w_tick;
  logic             w_reversal;
  logic             w_overtravel;
  logic [1:0]       w_new_code;
  logic [POS_W-1:0] w_position_d;
  logic [CNT_W-1:0] w_step_cnt_d;
  logic             w_moving_d;
  logic [31:0]      w_pos_ext;

  always_comb begin
    w_dir      = {lift_engine[0], lift_engine[1]};
    w_active   = (w_dir == DIR_UP) || (w_dir == DIR_DOWN);
    // A fresh or changed command restarts counting at 0 on this very cycle
    w_eff_cnt  = (w_dir == r_prev_dir) ? r_step_cnt : '0;
    w_tick     = w_active && (w_eff_cnt == LAST_CNT);
    w_reversal = ((w_dir == DIR_UP) && (r_prev_dir == DIR_DOWN)) ||
                 ((w_dir == DIR_DOWN) && (r_prev_dir == DIR_UP));
    w_overtravel = w_tick && (((w_dir == DIR_UP) && (r_position == TOP_POS)) ||
                              ((w_dir == DIR_DOWN) && (r_position == '0)));

    if (w_dir == DIR_BOTH) begin
      w_new_code = FC_BOTH;
    end else if (w_reversal) begin
      w_new_code = FC_REV;
    end else if (w_overtravel) begin
      w_new_code = FC_OVER;
    end else begin
      w_new_code = FC_NONE;
    end
  end

  always_comb begin
    w_position_d = r_position;
    w_step_cnt_d = '0;
    w_moving_d   = 1'b0;
    if (!r_fault && (w_new_code == FC_NONE) && w_active) begin
      w_moving_d = 1'b1;
      if (w_tick) begin
        w_position_d = (w_dir == DIR_UP) ? r_position + POS_W'(1) : r_position - POS_W'(1);
      end else begin
        w_step_cnt_d = w_eff_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_position   <= INIT_POS;
      r_step_cnt   <= '0;
      r_prev_dir   <= DIR_NONE;
      r_moving     <= 1'b0;
      r_fault      <= 1'b0;
      r_fault_code <= FC_NONE;
    end else begin
      r_position <= w_position_d;
      r_step_cnt <= w_step_cnt_d;
      r_prev_dir <= (w_dir == DIR_BOTH) ? DIR_NONE : w_dir;
      r_moving   <= w_moving_d;
      if (!r_fault && (w_new_code != FC_NONE)) begin
        r_fault      <= 1'b1;
        r_fault_code <= w_new_code;
      end
    end
  end

  // Detectors depend on the position register only, never on the engine input
  always_comb begin
    w_pos_ext          = 32'(r_position);
    lift_detector      = '0;
    lift_stop_detector = '0;
    for (int unsigned f = 0; f < FLOOR_NUM; f++) begin
      lift_detector[f]      = (w_pos_ext + HALF >= f * STEPS_PER_FLOOR) &&
                              (w_pos_ext + HALF < (f + 1) * STEPS_PER_FLOOR);
      lift_stop_detector[f] = (w_pos_ext == f * STEPS_PER_FLOOR);
    end
  end

  assign position   = r_position;
  assign moving     = r_moving;
  assign fault      = r_fault;
  assign fault_code = r_fault_code;

endmodule

// File: tb/tb_lift_shaft_model.sv
// Bench for lift_shaft_model: directed scenarios plus random command runs checked against a
// run-length based reference of the cab motion and fault rules.
module tb_lift_shaft_model;

  localparam int FN   = 16;
  localparam int SPF  = 8;
  localparam int SC   = 4;
  localparam int MAXP = (FN - 1) * SPF;

  logic          clk;
  logic          rst;
  logic [1:0]    eng;
  logic [1:0]    eng_top;
  logic [FN-1:0] det, stop_det, det_top, stop_top;
  logic [6:0]    pos, pos_top;
  logic          mov, mov_top, flt, flt_top;
  logic [1:0]    code, code_top;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference state: position, length of the current same-direction run, previous direction
  // (0 none, 1 up, 2 down), fault flag/code and moving flag.
  int m_pos, m_run, m_prev, m_fault, m_code, m_moving;

  lift_shaft_model dut (
    .clk               (clk),
    .rst               (rst),
    .lift_engine       (eng),
    .lift_detector     (det),
    .lift_stop_detector(stop_det),
    .position          (pos),
    .moving            (mov),
    .fault             (flt),
    .fault_code        (code)
  );

  lift_shaft_model #(.INIT_FLOOR(15)) dut_top (
    .clk               (clk),
    .rst               (rst),
    .lift_engine       (eng_top),
    .lift_detector     (det_top),
    .lift_stop_detector(stop_top),
    .position          (pos_top),
    .moving            (mov_top),
    .fault             (flt_top),
    .fault_code        (code_top)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic up, input logic dn, input logic rs);
    int d, np;
    d = (up && !dn) ? 1 : (!up && dn) ? 2 : (up && dn) ? 3 : 0;
    if (rs) begin
      m_pos = 0; m_run = 0; m_prev = 0; m_fault = 0; m_code = 0; m_moving = 0;
      return;
    end
    m_moving = 0;
    if (m_fault == 0) begin
      if (d == 3) begin
        m_fault = 1; m_code = 1;
      end else if ((d == 1 && m_prev == 2) || (d == 2 && m_prev == 1)) begin
        m_fault = 1; m_code = 3;
      end else if (d != 0) begin
        m_run = (d == m_prev) ? m_run + 1 : 1;
        if (m_run % SC == 0) begin
          np = m_pos + ((d == 1) ? 1 : -1);
          if (np < 0 || np > MAXP) begin
            m_fault = 1; m_code = 2;
          end else begin
            m_pos = np;
          end
        end
        if (m_fault == 0) m_moving = 1;
      end else begin
        m_run = 0;
      end
    end
    m_prev = (d == 3) ? 0 : d;
  endtask

  task automatic check_all();
    logic [31:0] e_det, e_stop;
    e_det  = 32'd1 << ((m_pos + SPF / 2) / SPF);
    e_stop = (m_pos % SPF == 0) ? (32'd1 << (m_pos / SPF)) : 32'd0;
    chk("position", 32'(pos), m_pos);
    chk("lift_detector", 32'(det), e_det);
    chk("lift_stop_detector", 32'(stop_det), e_stop);
    chk("moving", 32'(mov), m_moving);
    chk("fault", 32'(flt), m_fault);
    chk("fault_code", 32'(code), m_code);
  endtask

  task automatic cyc(input logic up, input logic dn);
    eng = {up, dn};
    @(posedge clk);
    model_step(up, dn, 1'b0);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    eng = 2'b00;
    eng_top = 2'b00;
    @(posedge clk);
    model_step(1'b0, 1'b0, 1'b1);
    #1;
    rst = 1'b0;
    check_all();
  endtask

  initial begin
    int r, len;
    logic u, d;
    rst = 1'b1;
    eng = 2'b00;
    eng_top = 2'b00;

    // Reset defaults
    do_reset();
    chk("reset_det", 32'(det), 32'h0001);
    chk("reset_stop", 32'(stop_det), 32'h0001);
    chk("reset_top_pos", 32'(pos_top), 120);
    chk("reset_top_stop", 32'(stop_top), 32'h8000);

    // Held up: one tick per four cycles
    cyc(1'b1, 1'b0);
    chk("first_moving", 32'(mov), 1);
    repeat (3) cyc(1'b1, 1'b0);
    chk("first_tick_pos", 32'(pos), 1);
    chk("stop0_dropped", 32'(stop_det), 0);
    repeat (12) cyc(1'b1, 1'b0);
    chk("pos_16", 32'(pos), 4);
    chk("det_16", 32'(det), 32'h0002);
    chk("stop_16", 32'(stop_det), 0);
    repeat (16) cyc(1'b1, 1'b0);
    chk("pos_32", 32'(pos), 8);
    chk("stop_32", 32'(stop_det), 32'h0002);

    // Interrupted command discards partial progress
    do_reset();
    repeat (3) cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    chk("gap_moving", 32'(mov), 0);
    repeat (3) cyc(1'b1, 1'b0);
    chk("gap_pos", 32'(pos), 0);
    chk("gap_moving2", 32'(mov), 1);
    chk("gap_fault", 32'(flt), 0);

    // Both directions, then sticky freeze
    do_reset();
    cyc(1'b1, 1'b1);
    chk("both_code", 32'(code), 1);
    repeat (20) cyc(1'b1, 1'b0);
    chk("frozen_pos", 32'(pos), 0);
    chk("frozen_fault", 32'(flt), 1);
    do_reset();
    chk("fault_cleared", 32'(flt), 0);

    // Direct reversal, and BOTH outranking a reversal-looking sequence
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b1);
    chk("rev_code", 32'(code), 3);
    do_reset();
    cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b1);
    chk("prio_code", 32'(code), 1);

    // Overtravel on the top-floor instance
    do_reset();
    eng_top = 2'b10;
    repeat (3) cyc(1'b0, 1'b0);
    chk("top_nofault", 32'(flt_top), 0);
    cyc(1'b0, 1'b0);
    chk("top_code", 32'(code_top), 2);
    chk("top_pos", 32'(pos_top), 120);
    chk("top_stop", 32'(stop_top), 32'h8000);
    chk("top_moving", 32'(mov_top), 0);
    eng_top = 2'b00;

    // Overtravel at floor 0 going down, and the full run up to the top stop
    do_reset();
    repeat (4) cyc(1'b0, 1'b1);
    chk("under_code", 32'(code), 2);
    do_reset();
    repeat (490) cyc(1'b1, 1'b0);
    chk("full_run_pos", 32'(pos), 120);
    chk("full_run_code", 32'(code), 2);

    // Random command episodes
    for (int ep = 0; ep < 25; ep++) begin
      do_reset();
      for (int seg = 0; seg < 10; seg++) begin
        r   = $urandom_range(0, 19);
        len = $urandom_range(1, 14);
        u   = (r < 10) || (r == 19);
        d   = ((r >= 10) && (r < 16)) || (r == 19);
        repeat (len) cyc(u, d);
        if ($urandom_range(0, 1) == 1) cyc(1'b0, 1'b0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
